apb_cmd_master: RTL

- Single-outstanding APB initiator. Turns a valid/ready command stream (addr, wdata, write) into APB3 setup/access transfers, and returns read data and error status on a valid/ready response stream.
- Drives the SoC control and peripheral APB slaves from debug, boot-sequencer or test logic, in place of the FC core.
- Tolerates multi-cycle slaves that pulse PREADY for one cycle.

---
 rtl/apb_cmd_master.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB3 initiator: valid/ready command stream in, valid/ready response stream out.
// Optional ACCESS-phase timeout abort is compiled in when APB_TIMEOUT_EN is defined.
module apb_cmd_master #(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_write_i,
    input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [31:0]               cmd_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      rsp_timeout_o,
    output logic                      busy_o,
    output logic [15:0]               xfer_cnt_o,
    output logic [15:0]               err_cnt_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);
    localparam int unsigned AW    = APB_ADDR_WIDTH;
    localparam int unsigned DW    = 32;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [DW-1:0]    TIMEOUT_DATA = 32'hDEAD_BEEF;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("apb_cmd_master: TIMEOUT_CYCLES must be 1..65535");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e           state_q;
    logic [AW-1:0]    paddr_q;
    logic [DW-1:0]    pwdata_q;
    logic             pwrite_q;
    logic             psel_q;
    logic             penable_q;
    logic             rsp_valid_q;
    logic [DW-1:0]    rsp_rdata_q;
    logic             rsp_err_q;
    logic             rsp_timeout_q;
    logic             busy_q;
    logic [CNT_W-1:0] xfer_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] xfer_cnt_d;
    logic [CNT_W-1:0] err_cnt_d;
    logic             timeout_c;
    logic             done_err_c;

    // Accept only from IDLE; held low during reset so nothing is lost in the reset cycle.
    assign cmd_ready_o = (state_q == S_IDLE) && !HRESET;

`ifdef APB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt_q;

    // Abort in the ACCESS cycle that would bring the stall count up to TIMEOUT_CYCLES.
    assign timeout_c = (state_q == S_ACCESS) && !PREADY && (wait_cnt_q == WAIT_LAST);

    always_ff @(posedge HCLK) begin
        if (HRESET || state_q == S_SETUP) begin
            wait_cnt_q <= '0;
        end else if (state_q == S_ACCESS && !PREADY) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    // Saturating counter updates for a completing transfer; PREADY wins over timeout.
    always_comb begin
        done_err_c = PREADY ? PSLVERR : 1'b1;
        xfer_cnt_d = (xfer_cnt_q == CNT_MAX) ? xfer_cnt_q : xfer_cnt_q + CNT_W'(1);
        err_cnt_d  = err_cnt_q;
        if (done_err_c && err_cnt_q != CNT_MAX) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q       <= S_IDLE;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pwrite_q      <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
            xfer_cnt_q    <= '0;
            err_cnt_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        paddr_q   <= cmd_addr_i & ~AW'(3);
                        pwdata_q  <= cmd_wdata_i;
                        pwrite_q  <= cmd_write_i;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (PREADY || timeout_c) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= done_err_c;
                        rsp_timeout_q <= !PREADY;
                        rsp_rdata_q   <= !PREADY  ? TIMEOUT_DATA :
                                         pwrite_q ? '0 : PRDATA;
                        xfer_cnt_q    <= xfer_cnt_d;
                        err_cnt_q     <= err_cnt_d;
                        state_q       <= S_RESP;
                    end
                end
                S_RESP: begin
                    // Returning to IDLE first guarantees two PSEL-low cycles between transfers.
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign PADDR         = paddr_q;
    assign PWDATA        = pwdata_q;
    assign PWRITE        = pwrite_q;
    assign PSEL          = psel_q;
    assign PENABLE       = penable_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign busy_o        = busy_q;
    assign xfer_cnt_o    = xfer_cnt_q;
    assign err_cnt_o     = err_cnt_q;

endmodule
